alu_arbiter: RTL

- Shares the single 32-bit integer ALU between N_REQ requesters, e.g. the EX-stage operand path and the branch-compare/address unit.
- Each grant drives the ALU's ctl/a/b operands, then captures the ALU's out and zero into a response register.
- The response is held until the requester accepts it.
- Sits between the pipeline requesters and the ALU instance; it owns the ALU input muxes.

---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_arbiter_rr_pick.sv | 30 +++
 rtl/alu_arbiter.sv | 102 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU control codes and arbiter state type.
package alu_pkg;

   localparam logic [3:0] ALU_OR  = 4'd1;
   localparam logic [3:0] ALU_ADD = 4'd2;
   localparam logic [3:0] ALU_SLT = 4'd7;
   localparam logic [3:0] ALU_NOR = 4'd12;
   localparam logic [3:0] ALU_XOR = 4'd13;

   typedef logic [3:0] alu_ctl_t;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } arb_state_t;

endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester after rr_ptr wins.
module rr_pick #(
   parameter int N_REQ = 2,
   parameter int IDX_W = 1
) (
   input  logic [N_REQ-1:0] valid,
   input  logic [IDX_W-1:0] rr_ptr,
   output logic [N_REQ-1:0] grant,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   always_comb begin
      logic [IDX_W-1:0] cand_idx;
      grant    = '0;
      idx      = '0;
      any      = 1'b0;
      cand_idx = '0;
      // Walk the ring starting just past the last winner; rr_ptr itself is checked last.
      for (int k = 1; k <= N_REQ; k++) begin
         cand_idx = IDX_W'((int'(rr_ptr) + k) % N_REQ);
         if (!any && valid[cand_idx]) begin
            any             = 1'b1;
            idx             = cand_idx;
            grant[cand_idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between N_REQ requesters; one operation per cycle, result held
// in a response register until its owner accepts it.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int N_REQ = 2,
   parameter int W     = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N_REQ-1:0]   req_valid,
   output logic [N_REQ-1:0]   req_ready,
   input  logic [4*N_REQ-1:0] req_ctl,
   input  logic [W*N_REQ-1:0] req_a,
   input  logic [W*N_REQ-1:0] req_b,
   output logic [N_REQ-1:0]   rsp_valid,
   input  logic [N_REQ-1:0]   rsp_ready,
   output logic [W-1:0]       rsp_out,
   output logic               rsp_zero,
   output logic [3:0]         alu_ctl,
   output logic [W-1:0]       alu_a,
   output logic [W-1:0]       alu_b,
   input  logic [W-1:0]       alu_out,
   input  logic               alu_zero
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   alu_ctl_t       ctl_arr [N_REQ];
   logic [W-1:0]   a_arr   [N_REQ];
   logic [W-1:0]   b_arr   [N_REQ];

   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
         assign ctl_arr[gi] = req_ctl[4*gi +: 4];
         assign a_arr[gi]   = req_a[W*gi +: W];
         assign b_arr[gi]   = req_b[W*gi +: W];
      end
   endgenerate

   arb_state_t       state_reg;
   logic [IDX_W-1:0] owner_reg;
   logic [IDX_W-1:0] rr_ptr_reg;
   logic [W-1:0]     rsp_out_reg;
   logic             rsp_zero_reg;

   logic [N_REQ-1:0] pick_grant;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_any;

   rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .valid  (req_valid),
      .rr_ptr (rr_ptr_reg),
      .grant  (pick_grant),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   logic drain;
   logic allowed;
   logic granted;

   // A draining owner frees the register in the same cycle a new result lands.
   assign drain   = (state_reg == HOLD) && rsp_ready[owner_reg];
   assign allowed = (state_reg == IDLE) || drain;
   assign granted = allowed && pick_any;

   assign req_ready = granted ? pick_grant         : '0;
   assign alu_ctl   = granted ? ctl_arr[pick_idx]  : 4'd0;
   assign alu_a     = granted ? a_arr[pick_idx]    : '0;
   assign alu_b     = granted ? b_arr[pick_idx]    : '0;

   always_comb begin
      rsp_valid = '0;
      if (state_reg == HOLD) rsp_valid[owner_reg] = 1'b1;
   end

   assign rsp_out  = rsp_out_reg;
   assign rsp_zero = rsp_zero_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         owner_reg    <= '0;
         rr_ptr_reg   <= IDX_W'(N_REQ - 1);
         rsp_out_reg  <= '0;
         rsp_zero_reg <= 1'b0;
      end else if (granted) begin
         state_reg    <= HOLD;
         owner_reg    <= pick_idx;
         rr_ptr_reg   <= pick_idx;
         rsp_out_reg  <= alu_out;
         rsp_zero_reg <= alu_zero;
      end else if (drain) begin
         state_reg    <= IDLE;
      end
   end

endmodule
